// File: rtl/target_packer.sv
// target_packer: packs four 32-bit results per 128-bit word into the target buffer wide write port.
// Optional wrap detection on err is enabled by defining TARGET_PACKER_WRAP_CHK_EN.
module target_packer #(
   parameter int DW    = 32,
   parameter int RATIO = 4,
   parameter int WA    = DW * RATIO,
   parameter int AW    = 12,
   parameter int CW    = 14
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [CW-1:0] num_results,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          wr_en,
   output logic          wr_we,
   output logic [AW-1:0] wr_addr,
   output logic [WA-1:0] wr_data,
   output logic          busy,
   output logic          done,
   output logic          err
);
   localparam int LW = RATIO > 1 ? $clog2(RATIO) : 1;
   typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;
   state_t state, state_nx;
   logic [AW-1:0] addr;
   logic [CW-1:0] remaining;
   logic [LW-1:0] lane_cnt;
   logic [WA-1:0] pack, pack_nx;
   logic hs, last, trig, accept;
   assign hs     = in_valid & in_ready;
   assign last   = hs && remaining == CW'(1);
   assign trig   = hs && (lane_cnt == LW'(RATIO - 1) || remaining == CW'(1));
   assign accept = state == IDLE && start;
   assign wr_we  = wr_en;
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state == IDLE ? (start ? (num_results == '0 ? DONE : PACK) : IDLE) :
                 state == PACK ? (last ? DONE : PACK) : IDLE;
   end
   always_comb begin
      in_ready = state == PACK;
      busy     = state == PACK;
      done     = state == DONE;
   end
   // current pack register with the incoming result dropped into its lane
   always_comb begin
      pack_nx = pack;
      for (int i = 0; i < RATIO; i++)
         if (LW'(i) == lane_cnt) pack_nx[i*DW +: DW] = in_data;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr      <= '0;
         remaining <= '0;
         lane_cnt  <= '0;
         pack      <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         wr_en <= trig;
         if (accept) begin
            addr      <= base_addr;
            remaining <= num_results;
            lane_cnt  <= '0;
            pack      <= '0;
         end
         if (hs) begin
            remaining <= remaining - CW'(1);
            lane_cnt  <= trig ? '0 : lane_cnt + LW'(1);
            pack      <= trig ? '0 : pack_nx;
         end
         if (trig) begin
            wr_data <= pack_nx;
            wr_addr <= addr;
            addr    <= addr + AW'(1);
         end
      end
   end
`ifdef TARGET_PACKER_WRAP_CHK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) err <= 1'b0;
      else if (accept) err <= 1'b0;
      else if (trig && &addr) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_target_packer.sv
// tb_target_packer: randomized self-checking bench for target_packer against a word-chunking model.
module tb_target_packer;
   localparam int DW = 32, AW = 12, CW = 14, WA = 128;
`ifdef TARGET_PACKER_WRAP_CHK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] num_results = '0;
   logic [DW-1:0] in_data = '0;
   logic in_ready, wr_en, wr_we, busy, done, err;
   logic [AW-1:0] wr_addr;
   logic [WA-1:0] wr_data;
   int checks = 0, errors = 0, done_cnt = 0, we_bad = 0;
   logic [AW-1:0] got_addr[$];
   logic [WA-1:0] got_data[$];
   logic got_done[$];
   logic [DW-1:0] stim[$];

   target_packer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .num_results(num_results), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_we(wr_we), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         got_addr.push_back(wr_addr);
         got_data.push_back(wr_data);
         got_done.push_back(done);
      end
      if (done) done_cnt++;
      if (wr_we !== wr_en) we_bad++;
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int n, input bit seq, input logic [DW-1:0] first);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(seq ? first + DW'(i) : DW'($urandom));
   endtask

   task automatic run_job(input logic [AW-1:0] base, input int n, input int max_gap);
      logic [AW-1:0] ea[$];
      logic [WA-1:0] ed[$];
      logic [WA-1:0] w;
      int waited;
      for (int k = 0; k * 4 < n; k++) begin
         w = '0;
         for (int j = 0; j < 4 && k * 4 + j < n; j++) w[j*DW +: DW] = stim[k*4+j];
         ea.push_back(base + AW'(k));
         ed.push_back(w);
      end
      got_addr.delete(); got_data.delete(); got_done.delete();
      done_cnt = 0;
      start = 1; base_addr = base; num_results = CW'(n);
      step;
      start = 0;
      if (n == 0) chk("zero_len_done", done, 1);
      else chk("busy_after_start", busy, 1);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(max_gap, 0)) begin
            in_valid = 0; start = 1'($urandom); base_addr = AW'($urandom); num_results = CW'($urandom);
            step;
         end
         start = 1'($urandom); in_valid = 1; in_data = stim[i]; waited = 0;
         while (!in_ready && waited < 20) begin step; waited++; end
         step;
      end
      in_valid = 0; start = 0;
      if (n > 0) begin
         chk("final_wr_en", wr_en, 1);
         chk("final_done", done, 1);
         chk("final_ready_drop", in_ready, 0);
      end
      repeat (3) step;
      chk("wr_count", got_addr.size(), ea.size());
      for (int k = 0; k < ea.size() && k < got_addr.size(); k++) begin
         chk("wr_addr", got_addr[k], ea[k]);
         chk("wr_data", got_data[k], ed[k]);
      end
      if (got_done.size() > 0) chk("done_with_last_write", got_done[got_done.size()-1], 1);
      chk("done_pulses", done_cnt, 1);
      chk("idle_busy", busy, 0);
      chk("we_equals_en", we_bad, 0);
   endtask

   initial begin
      rst_n = 0; in_valid = 1; in_data = 32'hDEAD_BEEF; start = 1;
      repeat (3) begin
         step;
         chk("reset_flags", {in_ready, wr_en, wr_we, busy, done, err, wr_addr}, 0);
         chk("reset_data", wr_data, 0);
      end
      rst_n = 1; in_valid = 0; start = 0;
      step;
      fill(8, 1, 1);
      run_job(12'h010, 8, 0);
      chk("job1_word0", got_data[0], 128'h00000004_00000003_00000002_00000001);
      chk("job1_word1", got_data[1], 128'h00000008_00000007_00000006_00000005);
      chk("job1_addr1", got_addr[1], 12'h011);
      chk("job1_err", err, 0);
      fill(6, 1, 32'hA);
      run_job(12'h100, 6, 0);
      chk("partial_word1", got_data[1], 128'h0000000F_0000000E);
      chk("partial_addr1", got_addr[1], 12'h101);
      fill(8, 1, 1);
      run_job(12'h010, 8, 4);
      chk("gap_word0", got_data[0], 128'h00000004_00000003_00000002_00000001);
      for (int r = 0; r < 5; r++) begin
         fill($urandom_range(13, 1), 0, 0);
         run_job(AW'($urandom_range(12'hFF0, 0)), stim.size(), 3);
      end
      fill(0, 1, 0);
      run_job(12'h050, 0, 0);
      fill(8, 1, 32'h100);
      run_job(12'hFFF, 8, 1);
      chk("wrap_addr0", got_addr[0], 12'hFFF);
      chk("wrap_addr1", got_addr[1], 12'h000);
      chk("wrap_err_set", err, EXP_ERR);
      fill(0, 1, 0);
      run_job(12'h000, 0, 0);
      chk("wrap_err_cleared", err, 0);
      start = 1; base_addr = 12'h020; num_results = 4;
      step;
      start = 0; in_valid = 1; in_data = 32'h11;
      step;
      in_data = 32'h22;
      step;
      got_addr.delete(); got_data.delete(); got_done.delete();
      rst_n = 0;
      repeat (2) begin
         step;
         chk("midrst_flags", {wr_en, busy, in_ready, done}, 0);
      end
      rst_n = 1; in_valid = 0;
      step;
      step;
      chk("midrst_no_write", got_addr.size(), 0);
      fill(4, 1, 32'h55);
      run_job(12'h030, 4, 1);
      chk("midrst_lane0", got_data[0], 128'h00000058_00000057_00000056_00000055);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
